// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared sizes and state encoding for the input loader
package loader_pkg;

   localparam int ADDR_W    = 13;
   localparam int DATA_W    = 12;
   localparam int MAX_WORDS = 8192;
   localparam int LEN_W     = 14;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      B0,
      B1,
      B2,
      DONE,
      ERR
   } state_t;

   // States in which the loader is consuming the host byte stream
   function automatic logic accepts_bytes(input state_t s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == B0) || (s == B1) || (s == B2);
   endfunction

endpackage

// File: rtl/input_loader_if.sv
// rtl/input_loader_if.sv - host byte stream in, input-array write port out
interface input_loader_if #(
   parameter int ADDR_W = loader_pkg::ADDR_W,
   parameter int DATA_W = loader_pkg::DATA_W
);

   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              in1_write;
   logic [ADDR_W-1:0] addr_in;
   logic [DATA_W-1:0] data_in;

   // Host / bench side: offers bytes, observes array writes
   modport master (
      output rx_valid, rx_data,
      input  rx_ready, in1_write, addr_in, data_in
   );

   // Loader side
   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, in1_write, addr_in, data_in
   );

endinterface

// File: rtl/input_loader_word_packer.sv
// rtl/input_loader_word_packer.sv - packs byte triples into two 12-bit words
module word_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_b0,
   input  logic        load_b1,
   input  logic [7:0]  rx_byte,
   output logic [11:0] w0,
   output logic [11:0] w1
);

   logic [7:0] b0_q;
   logic [3:0] b1_hi_q;

   // Hold b0 whole and only the upper nibble of b1; the lower nibble of b1
   // is consumed directly from the bus when it completes w0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b0_q    <= '0;
         b1_hi_q <= '0;
      end else begin
         if (load_b0) b0_q    <= rx_byte;
         if (load_b1) b1_hi_q <= rx_byte[7:4];
      end
   end

   assign w0 = {rx_byte[3:0], b0_q};
   assign w1 = {rx_byte, b1_hi_q};

endmodule

// File: rtl/input_loader.sv
// rtl/input_loader.sv - length-prefixed byte stream to input-array word loader
module input_loader #(
   parameter int ADDR_W = loader_pkg::ADDR_W,
   parameter int DATA_W = loader_pkg::DATA_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input_loader_if.slave  bus,
   output logic           busy,
   output logic           done,
   output logic           error
);

   import loader_pkg::*;

   state_t            state;
   logic [7:0]        len_lo;
   logic [LEN_W-1:0]  n_words;
   logic [LEN_W-1:0]  wr_cnt;
   logic              in1_write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              done_q;
   logic              error_q;

   logic              accept;
   logic              last_word;
   logic [LEN_W-1:0]  len_field;
   logic [11:0]       w0;
   logic [11:0]       w1;

   assign bus.rx_ready  = accepts_bytes(state);
   assign busy          = accepts_bytes(state);
   assign accept        = bus.rx_valid && bus.rx_ready;
   assign len_field     = {bus.rx_data[5:0], len_lo};
   assign last_word     = (wr_cnt + LEN_W'(1)) == n_words;

   assign bus.in1_write = in1_write_q;
   assign bus.addr_in   = addr_q;
   assign bus.data_in   = data_q;
   assign done          = done_q;
   assign error         = error_q;

   word_packer u_packer (
      .clk     (clk),
      .rst     (rst),
      .load_b0 (accept && !start && (state == B0)),
      .load_b1 (accept && !start && (state == B1)),
      .rx_byte (bus.rx_data),
      .w0      (w0),
      .w1      (w1)
   );

   // Loader FSM with address counter; start overrides any byte in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         len_lo      <= '0;
         n_words     <= '0;
         wr_cnt      <= '0;
         in1_write_q <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         in1_write_q <= 1'b0;
         if (start) begin
            state   <= LEN_LO;
            wr_cnt  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
         end else if (accept) begin
            case (state)
               LEN_LO: begin
                  len_lo <= bus.rx_data;
                  state  <= LEN_HI;
               end
               LEN_HI: begin
                  n_words <= len_field;
                  if (len_field > LEN_W'(MAX_WORDS)) begin
                     state   <= ERR;
                     error_q <= 1'b1;
                  end else if (len_field == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= B0;
                  end
               end
               B0: state <= B1;
               B1: begin
                  in1_write_q <= 1'b1;
                  addr_q      <= wr_cnt[ADDR_W-1:0];
                  data_q      <= DATA_W'(w0);
                  wr_cnt      <= wr_cnt + LEN_W'(1);
                  if (last_word) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= B2;
                  end
               end
               B2: begin
                  in1_write_q <= 1'b1;
                  addr_q      <= wr_cnt[ADDR_W-1:0];
                  data_q      <= DATA_W'(w1);
                  wr_cnt      <= wr_cnt + LEN_W'(1);
                  if (last_word) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= B0;
                  end
               end
               default: state <= state;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_input_loader.sv
// tb/tb_input_loader.sv - randomized self-checking bench for input_loader
module tb_input_loader;
   import loader_pkg::*;

   typedef logic [7:0] byte_q_t [$];
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              done_at;
   } obs_t;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy;
   logic done;
   logic error;

   int      checks   = 0;
   int      failures = 0;
   obs_t    obs_q [$];
   wr_t     exp_q [$];
   byte_q_t stim;
   bit      e_tmp;

   input_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   input_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done),
      .error (error)
   );

   always #5 clk = ~clk;

   // Record every array write together with the done flag of the same cycle
   always @(negedge clk) begin
      if (bus.in1_write === 1'b1) obs_q.push_back({bus.addr_in, bus.data_in, done});
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: expected write list straight from the length/packing rules
   task automatic model(input byte_q_t b, output bit e);
      logic [7:0]        lo, hi, x, y, z;
      logic [DATA_W-1:0] d;
      int                n, base;
      exp_q.delete();
      lo = b[0];
      hi = b[1];
      n  = int'({hi[5:0], lo});
      e  = (n > MAX_WORDS);
      if (!e) begin
         for (int i = 0; i < n; i++) begin
            base = 2 + 3 * (i / 2);
            y    = b[base + 1];
            if (i % 2 == 0) begin
               x = b[base];
               d = {y[3:0], x};
            end else begin
               z = b[base + 2];
               d = {z, y[7:4]};
            end
            exp_q.push_back({ADDR_W'(i), d});
         end
      end
   endtask

   task automatic make_stream(input int n, input bit rand_top, output byte_q_t b);
      logic [13:0] nn;
      logic [1:0]  top;
      int          nb;
      nn  = n[13:0];
      top = rand_top ? 2'($urandom) : 2'b00;
      b.delete();
      b.push_back(nn[7:0]);
      b.push_back({top, nn[13:8]});
      nb = (n > MAX_WORDS) ? 0 : 3 * (n / 2) + 2 * (n % 2);
      for (int i = 0; i < nb; i++) b.push_back(8'($urandom));
   endtask

   // Called just after a falling edge; returns just after the falling edge
   // that follows the acceptance of the byte.
   task automatic send_byte(input logic [7:0] v, input int max_stall);
      int st;
      st = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
      bus.rx_valid = 1'b0;
      repeat (st) begin
         bus.rx_data = 8'($urandom);
         @(negedge clk);
      end
      bus.rx_data  = v;
      bus.rx_valid = 1'b1;
      check("rx_ready_when_offered", bus.rx_ready, 1);
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      obs_q.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic compare_writes();
      int f0, m;
      check("write_count", obs_q.size(), exp_q.size());
      m  = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      f0 = failures;
      for (int i = 0; i < m; i++) begin
         check("write_addr", obs_q[i].addr, exp_q[i].addr);
         check("write_data", obs_q[i].data, exp_q[i].data);
         if (failures != f0) break;
      end
      if (m > 0 && obs_q.size() == exp_q.size()) check("done_with_final_write", obs_q[m-1].done_at, 1);
      if (m > 1) check("done_low_on_first_write", obs_q[0].done_at, 0);
   endtask

   task automatic send_stream(input byte_q_t b, input int max_stall);
      bit e;
      model(b, e);
      foreach (b[i]) send_byte(b[i], max_stall);
      check("done_after_last", done, !e);
      check("error_after_last", error, e);
      if (exp_q.size() > 0) check("last_write_with_done", bus.in1_write, 1);
      check("busy_after_last", busy, 0);
      check("rx_ready_after_last", bus.rx_ready, 0);
      bus.rx_data  = 8'($urandom);
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      compare_writes();
   endtask

   task automatic run_load(input byte_q_t b, input int max_stall);
      pulse_start();
      check("busy_after_start", busy, 1);
      check("done_cleared_by_start", done, 0);
      check("error_cleared_by_start", error, 0);
      send_stream(b, max_stall);
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_rx_ready", bus.rx_ready, 0);
      check("reset_in1_write", bus.in1_write, 0);
      check("reset_addr_in", bus.addr_in, 0);
      check("reset_data_in", bus.data_in, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_error", error, 0);
      rst = 1'b0;

      // Idle block ignores bytes until start
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h03;
      repeat (3) @(negedge clk);
      bus.rx_valid = 1'b0;
      check("idle_rx_ready", bus.rx_ready, 0);
      check("idle_busy", busy, 0);
      check("idle_no_writes", obs_q.size(), 0);

      // Basic N=3 load
      stim = '{8'h03, 8'h00, 8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34};
      run_load(stim, 0);
      if (obs_q.size() == 3) begin
         check("basic_w0", {19'd0, obs_q[0].addr, obs_q[0].data}, {19'd0, 13'd0, 12'hDAB});
         check("basic_w1", {19'd0, obs_q[1].addr, obs_q[1].data}, {19'd0, 13'd1, 12'hEFC});
         check("basic_w2", {19'd0, obs_q[2].addr, obs_q[2].data}, {19'd0, 13'd2, 12'h412});
      end

      // Odd count, single word
      stim = '{8'h01, 8'h00, 8'h55, 8'hF7};
      run_load(stim, 0);
      if (obs_q.size() == 1) check("odd_w0", obs_q[0].data, 12'h755);

      // Illegal and zero length
      stim = '{8'h01, 8'h21};
      run_load(stim, 0);
      stim = '{8'h00, 8'h00};
      run_load(stim, 0);

      // Length boundaries, with ignored top bits of LEN_HI randomized
      make_stream(MAX_WORDS + 1, 1, stim);
      run_load(stim, 0);
      make_stream(MAX_WORDS, 1, stim);
      run_load(stim, 0);

      // Random lengths: continuous stream and the same stream with stalls
      for (int k = 0; k < 5; k++) begin
         make_stream(int'($urandom_range(40, 1)), 1, stim);
         run_load(stim, 0);
         run_load(stim, 3);
      end

      // Restart with start while waiting for b1 of the third triple
      make_stream(12, 1, stim);
      model(stim, e_tmp);
      pulse_start();
      for (int i = 0; i < 9; i++) send_byte(stim[i], 2);
      check("pre_restart_writes", obs_q.size(), 4);
      if (obs_q.size() >= 4) check("pre_restart_last_data", obs_q[3].data, exp_q[3].data);
      check("pre_restart_busy", busy, 1);
      obs_q.delete();
      start        = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      check("restart_busy", busy, 1);
      check("restart_no_write", bus.in1_write, 0);
      make_stream(7, 1, stim);
      send_stream(stim, 0);
      if (obs_q.size() > 0) check("restart_first_addr", obs_q[0].addr, 0);

      // Asynchronous reset in the middle of a write cycle
      make_stream(10, 0, stim);
      pulse_start();
      for (int i = 0; i < 5; i++) send_byte(stim[i], 0);
      check("write_before_reset", bus.in1_write, 1);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_rx_ready", bus.rx_ready, 0);
      check("midrst_in1_write", bus.in1_write, 0);
      check("midrst_addr_in", bus.addr_in, 0);
      check("midrst_data_in", bus.data_in, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_error", error, 0);
      @(negedge clk);
      rst = 1'b0;
      obs_q.delete();
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h05;
      repeat (4) @(negedge clk);
      bus.rx_valid = 1'b0;
      check("postrst_rx_ready", bus.rx_ready, 0);
      check("postrst_busy", busy, 0);
      check("postrst_done", done, 0);
      check("postrst_no_writes", obs_q.size(), 0);
      make_stream(5, 1, stim);
      run_load(stim, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/input_loader.md
INPUT_LOADER -- requirements
Module: input_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 13: width of the input-array word address.
REQ-002 SHALL have parameter DATA_W, default 12: width of an input-array word.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins, or restarts, a load.
REQ-006 SHALL have port rx_valid, input, 1: a byte is offered on rx_data.
REQ-007 SHALL have port rx_data, input, 8: the byte stream from the host link.
REQ-008 SHALL have port rx_ready, output, 1: the loader accepts a byte this cycle.
REQ-009 SHALL have port in1_write, output, 1: write strobe to the input array.
REQ-010 SHALL have port addr_in, output, ADDR_W: write address to the input array.
REQ-011 SHALL have port data_in, output, DATA_W: write data to the input array.
REQ-012 SHALL have port busy, output, 1: a load is in progress.
REQ-013 SHALL have port done, output, 1: sticky, set when the last word has been written.
REQ-014 SHALL have port error, output, 1: sticky, set when the length field is illegal.

Function
REQ-015 SHALL accept a byte only in a cycle where rx_valid and rx_ready are both high.
REQ-016 SHALL implement states IDLE, LEN_LO, LEN_HI, B0, B1, B2, DONE and ERR.
REQ-017 SHALL drive rx_ready high only in LEN_LO, LEN_HI, B0, B1 and B2.
REQ-018 SHALL take start in any state to LEN_LO, zero the word address and clear done and error; start has priority over a byte accepted in the same cycle, and that byte is dropped.
REQ-019 SHALL form the word count as N = {LEN_HI[5:0], LEN_LO}, 14 bits.
REQ-020 SHALL handle the length field as follows: N > 8192 goes to ERR; N = 0 goes to DONE; otherwise it goes to B0.
REQ-021 SHALL pack each triple of bytes b0, b1, b2 into two words: w0 = {b1[3:0], b0} and w1 = {b2, b1[7:4]}.
REQ-022 SHALL pulse in1_write for exactly one cycle, in the cycle after the byte that completes a word is accepted, with addr_in and data_in valid in that same cycle.
REQ-023 SHALL write words to addresses 0, 1, 2 and so on, incrementing the address after each write.
REQ-024 SHALL, for odd N, complete the final word with b0 and b1 only, ignore b1[7:4], and go from B1 to DONE.
REQ-025 SHALL go to DONE when the Nth write is issued; done rises in the same cycle as that final in1_write.
REQ-026 SHALL hold addr_in and data_in at their last written values between writes.
REQ-027 SHALL drive busy high exactly when the state is LEN_LO, LEN_HI, B0, B1 or B2.
REQ-028 SHALL treat rx_valid stalls of any length as idle cycles, with no state change and no write.

Reset
REQ-029 SHALL, on rst, immediately force the state to IDLE and force rx_ready, in1_write, addr_in, data_in, busy, done and error all to 0.
REQ-030 SHALL abandon a load interrupted by rst mid-operation; after release, the block waits for start.

Structure
REQ-031 SHALL place the state enumeration, ADDR_W, DATA_W and MAX_WORDS (8192) in a shared package, loader_pkg.
REQ-032 SHALL allow one sub-module, word_packer (byte-triple to word logic plus its byte holding register); the FSM and address counter stay in input_loader.

Verification
REQ-033 SHALL cover a basic load: start, then bytes 03 00 AB CD EF -> writes addr0=DAB, addr1=EFC, addr2 from the next pair; with N=3, send 03 00 AB CD EF 12 34 -> third write addr2=412, then done=1.
REQ-034 SHALL cover an odd count: bytes 01 00 55 F7 -> a single write addr0=755, then done, with rx_ready=0 afterwards.
REQ-035 SHALL cover an illegal length: bytes 01 21 (N=8449) -> error=1, no writes, rx_ready=0.
REQ-036 SHALL cover a zero length: bytes 00 00 -> done=1 in the cycle after LEN_HI is accepted, no writes.
REQ-037 SHALL cover a restart: start during B1 of word 5 -> the next write goes to address 0; a random rx_valid stall pattern gives the same write sequence as a continuous stream.
REQ-038 SHALL cover reset: rst asserted mid-load -> all outputs are 0 within the same cycle, and the block stays in IDLE until start.
